// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - memory write drain port of the store buffer
interface store_buffer_if #(
    parameter int ADDR_WIDTH = 15
) ();
    logic                  mem_wr_valid;
    logic                  mem_wr_ready;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [31:0]           mem_wr_data;
    logic [3:0]            mem_wr_be;

    modport master (
        output mem_wr_valid,
        output mem_wr_addr,
        output mem_wr_data,
        output mem_wr_be,
        input  mem_wr_ready
    );

    modport slave (
        input  mem_wr_valid,
        input  mem_wr_addr,
        input  mem_wr_data,
        input  mem_wr_be,
        output mem_wr_ready
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer with speculative entries, load lookup and memory drain
module store_buffer #(
    parameter int         ADDR_WIDTH = 15,
    parameter int         DEPTH      = 4,
    parameter logic [6:0] SB         = 7'd16,
    parameter logic [6:0] SH         = 7'd17,
    parameter logic [6:0] SW         = 7'd18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            decoded_opcode_MEM_next,
    input  logic [63:0]           op1_MEM_next,
    input  logic [63:0]           op2_MEM_next,
    input  logic [31:0]           imm_MEM_next,
    input  logic                  speculative,
    input  logic                  prediction_success,
    input  logic                  prediction_failed,
    input  logic                  search_store_buffer,
    input  logic [ADDR_WIDTH-1:0] computed_addr,
    output logic                  store_buffer_match,
    output logic                  sb_full,
    output logic                  sb_empty,
    store_buffer_if.master        mem_wr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_WIDTH - 2;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_spec;
    logic [WA_W-1:0]  ent_waddr [DEPTH];
    logic [3:0]       ent_be    [DEPTH];
    logic [31:0]      ent_data  [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [63:0]           imm_ext;
    logic [63:0]           addr_sum;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic                  is_store;
    logic [3:0]            st_be;
    logic [31:0]           st_data;
    logic [CNT_W-1:0]      spec_cnt;
    logic [CNT_W-1:0]      rollback;
    logic [PTR_W-1:0]      tail_base;
    logic                  drain_valid;
    logic                  pop;
    logic                  enq;
    logic                  unused_bits;

    assign imm_ext  = {{32{imm_MEM_next[31]}}, imm_MEM_next};
    assign addr_sum = op1_MEM_next + imm_ext;
    assign st_addr  = addr_sum[ADDR_WIDTH-1:0];
    assign is_store = (decoded_opcode_MEM_next == SB) ||
                      (decoded_opcode_MEM_next == SH) ||
                      (decoded_opcode_MEM_next == SW);

    assign unused_bits = ^{addr_sum[63:ADDR_WIDTH], op2_MEM_next[63:32], computed_addr[1:0]};

    // Data is placed in its byte lanes so the drain port writes the word as-is.
    always_comb begin
        st_be   = 4'b0000;
        st_data = 32'h0;
        if (decoded_opcode_MEM_next == SW) begin
            st_be   = 4'b1111;
            st_data = op2_MEM_next[31:0];
        end else if (decoded_opcode_MEM_next == SH) begin
            st_be   = st_addr[1] ? 4'b1100 : 4'b0011;
            st_data = st_addr[1] ? {op2_MEM_next[15:0], 16'h0} : {16'h0, op2_MEM_next[15:0]};
        end else if (decoded_opcode_MEM_next == SB) begin
            st_be   = 4'b0001 << st_addr[1:0];
            st_data = {24'h0, op2_MEM_next[7:0]} << {st_addr[1:0], 3'b000};
        end
    end

    always_comb begin
        spec_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            spec_cnt = spec_cnt + CNT_W'(ent_valid[i] & ent_spec[i]);
        end
    end

    always_comb begin
        store_buffer_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (search_store_buffer && ent_valid[i] &&
                ent_waddr[i] == computed_addr[ADDR_WIDTH-1:2]) begin
                store_buffer_match = 1'b1;
            end
        end
    end

    assign drain_valid         = ent_valid[head] & ~ent_spec[head];
    assign pop                 = drain_valid & mem_wr.mem_wr_ready;
    assign mem_wr.mem_wr_valid = drain_valid;
    assign mem_wr.mem_wr_addr  = drain_valid ? {ent_waddr[head], 2'b00} : '0;
    assign mem_wr.mem_wr_data  = drain_valid ? ent_data[head] : 32'h0;
    assign mem_wr.mem_wr_be    = drain_valid ? ent_be[head] : 4'b0000;

    // Speculative entries always sit contiguously at the tail, so a squash is a tail rewind.
    assign rollback  = prediction_failed ? spec_cnt : '0;
    assign tail_base = tail - rollback[PTR_W-1:0];
    assign enq       = is_store && (count < FULL_COUNT) && !(speculative && prediction_failed);

    assign sb_full  = (count == FULL_COUNT);
    assign sb_empty = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid <= '0;
            ent_spec  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (prediction_failed && ent_spec[i]) begin
                    ent_valid[i] <= 1'b0;
                    ent_spec[i]  <= 1'b0;
                end else if (prediction_success) begin
                    ent_spec[i] <= 1'b0;
                end
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (enq) begin
                ent_valid[tail_base] <= 1'b1;
                ent_spec[tail_base]  <= speculative & ~prediction_success;
                ent_waddr[tail_base] <= st_addr[ADDR_WIDTH-1:2];
                ent_be[tail_base]    <= st_be;
                ent_data[tail_base]  <= st_data;
            end
            tail  <= tail_base + PTR_W'(enq);
            count <= count - rollback - CNT_W'(pop) + CNT_W'(enq);
        end
    end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 15, memory byte-address width; DEPTH, default 4, entry count (power of two); SB, default 7'd16; SH, default 7'd17; SW, default 7'd18 (store opcodes).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- decoded_opcode_MEM_next  input  7  issuing MEM-stage opcode
- op1_MEM_next  input  64  base register value
- op2_MEM_next  input  64  store data (bits 31:0 used)
- imm_MEM_next  input  32  signed offset
- speculative  input  1  issuing store is under an unresolved branch
- prediction_success  input  1  branch resolved correct
- prediction_failed  input  1  branch resolved wrong
- search_store_buffer  input  1  load address lookup request
- computed_addr  input  ADDR_WIDTH  load byte address
- store_buffer_match  output  1  lookup hit
- sb_full  output  1  count==DEPTH; MEM issue of stores stalls
- sb_empty  output  1  count==0
- mem_wr_valid  output  1  drain request
- mem_wr_ready  input  1  memory accepts write
- mem_wr_addr  output  ADDR_WIDTH  word-aligned drain address
- mem_wr_data  output  32  drain data, lane-positioned
- mem_wr_be  output  4  byte enables

Function
REQ-003 SHALL detect a store when decoded_opcode_MEM_next is SB, SH or SW; all other opcodes are ignored.
REQ-004 SHALL compute the store address as op1_MEM_next[ADDR_WIDTH-1:0] + signed imm_MEM_next, truncated to ADDR_WIDTH (wrap-around, no overflow flag).
REQ-005 SHALL enqueue a detected store at the tail at the next clk edge when count<DEPTH; when full, the store is dropped (upstream must honour sb_full).
REQ-006 SHALL store per entry: valid, spec, word address (addr[ADDR_WIDTH-1:2]), 4-bit byte enable, 32-bit lane-positioned data.
REQ-007 SHALL encode: SW -> be=4'b1111, data=op2[31:0]; SH -> be=4'b0011<<(2*addr[1]), data=op2[15:0] in the selected half; SB -> be=4'b0001<<addr[1:0], data=op2[7:0] in the selected byte; other lanes zero.
REQ-008 SHALL drive store_buffer_match=1 combinationally when search_store_buffer=1 and any valid entry (spec or not) has word address equal to computed_addr[ADDR_WIDTH-1:2]; 0 otherwise; same-cycle incoming store is not searched.
REQ-009 SHALL assert mem_wr_valid when the head entry is valid and not spec, with mem_wr_addr={head word addr,2'b00}, mem_wr_data, mem_wr_be from the head.
REQ-010 SHALL pop the head on a clk edge with mem_wr_valid && mem_wr_ready; drain strictly in FIFO order, one entry per cycle max.
REQ-011 SHALL allow enqueue and pop in the same cycle; count unchanged; at full, enqueue is evaluated on pre-pop count (rejected).
REQ-012 SHALL on prediction_success clear spec on all entries at the next edge.
REQ-013 SHALL on prediction_failed invalidate all spec entries at the next edge, moving tail back by the number of spec entries (spec entries are contiguous at the tail); non-spec entries and the head pop proceed unaffected.
REQ-014 SHALL drop a same-cycle speculative incoming store when prediction_failed=1; a non-speculative one is enqueued behind surviving entries.
REQ-015 SHALL enqueue a same-cycle speculative store with spec=0 when prediction_success=1.
REQ-016 SHALL wrap head/tail pointers modulo DEPTH.

Reset
REQ-017 SHALL on reset clear all valid/spec bits, head, tail and count to 0, overriding any same-cycle enqueue, pop or resolution.
REQ-018 SHALL produce after reset: sb_empty=1, sb_full=0, mem_wr_valid=0, store_buffer_match=0, mem_wr_addr=0, mem_wr_data=0, mem_wr_be=0.

Verification
REQ-019 SW op1=0x100, imm=4, op2=0xDEADBEEF, speculative=0, mem_wr_ready=0 -> next cycle mem_wr_valid=1, addr=0x104, data=0xDEADBEEF, be=4'b1111; ready=1 -> pop, sb_empty=1.
REQ-020 SB op1=0x203, imm=0, op2=0xAB -> be=4'b1000, data=0xAB000000; lookup computed_addr=0x200 -> match=1; 0x204 -> match=0.
REQ-021 Four stores, ready=0 -> sb_full=1; fifth store dropped; ready=1 for 4 cycles -> four writes in issue order, then sb_empty=1.
REQ-022 Non-spec store A, then spec stores B,C; prediction_failed -> count=1, only A drains; lookup on B's address -> match=0.
REQ-023 Spec store at head -> mem_wr_valid=0; prediction_success -> mem_wr_valid=1 next cycle.
REQ-024 Full buffer with pending drain, reset asserted one cycle -> all outputs at REQ-018 values, no write issued that cycle.
